// File: rtl/graph_unary_lut_stream.sv
// Streaming sequencer: reads int8 elements from scratchpad, drives them through the unary-op LUT
// and writes the results back at 1 element/cycle. Optional busy-cycle counter: GRAPH_UNARY_PERF_EN.
module graph_unary_lut_stream #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        lut_addr,
    input  logic [7:0]        lut_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [31:0]       perf_cycles
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d, i_q, i_d;
    logic              drain_q, drain_d;
    logic              accept;

    // Two-stage pipeline carrying the destination address alongside the in-flight element.
    logic              rd_valid_q, lut_valid_q;
    logic [ADDR_W-1:0] rd_waddr_q, lut_waddr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            i_q     <= i_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        i_d     = i_q;
        drain_d = drain_q;
        accept  = 1'b0;
        rd_en   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    src_d   = src_base;
                    dst_d   = dst_base;
                    len_d   = length;
                    i_d     = '0;
                    drain_d = 1'b0;
                    state_d = (length == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                rd_en = 1'b1;
                i_d   = i_q + 1'b1;
                if (i_q == len_q - 1'b1) state_d = StDrain;
            end
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q  <= 1'b0;
            rd_waddr_q  <= '0;
            lut_valid_q <= 1'b0;
            lut_waddr_q <= '0;
        end else begin
            rd_valid_q  <= (state_q == StRead);
            rd_waddr_q  <= dst_q + ADDR_W'(i_q);
            lut_valid_q <= rd_valid_q;
            lut_waddr_q <= rd_waddr_q;
        end
    end

    assign busy     = (state_q != StIdle);
    assign rd_addr  = src_q + ADDR_W'(i_q);
    assign lut_addr = rd_data;
    assign wr_en    = lut_valid_q;
    assign wr_addr  = lut_waddr_q;
    assign wr_data  = lut_data;

`ifdef GRAPH_UNARY_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_graph_unary_lut_stream.sv
// Directed self-checking bench for graph_unary_lut_stream with SRAM and SQRT-LUT models.
module tb_graph_unary_lut_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_base = '0, dst_base = '0, length = '0;
    logic        busy, done, rd_en, wr_en;
    logic [15:0] rd_addr, wr_addr;
    logic [7:0]  rd_data = '0, lut_addr, lut_data = '0, wr_data;
    logic [31:0] perf_cycles;

    logic [7:0]  mem [0:65535];

    int errors = 0;
    int checks = 0;

    logic [15:0] rd_a[$];
    int          rd_c[$];
    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    int          wr_c[$];
    int          done_cyc;
    int          busy_cnt;

    graph_unary_lut_stream #(.ADDR_W(16), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
        .length(length), .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .lut_addr(lut_addr), .lut_data(lut_data), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    // SQRT LUT: negative int8 clamps to 0, else floor(sqrt(x*32)).
    function automatic logic [7:0] sqrt_model(input logic [7:0] x);
        int v, r;
        if (x[7]) return 8'h00;
        v = int'(x) * 32;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r[7:0];
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        lut_data <= sqrt_model(lut_addr);
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Issues one command (start sampled at cycle 0) and logs traffic until done or budget runs out.
    task automatic run_op(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input int restart_cyc);
        rd_a.delete(); rd_c.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete();
        done_cyc = -1;
        busy_cnt = 0;
        @(negedge clk);
        src_base = s; dst_base = d; length = l; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= int'(l) + 20; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (rd_en) begin rd_a.push_back(rd_addr); rd_c.push_back(c); end
            if (wr_en) begin wr_a.push_back(wr_addr); wr_d.push_back(wr_data); wr_c.push_back(c); end
            start = (c == restart_cyc);
            if (c == restart_cyc) begin src_base = 16'h9999; dst_base = 16'h9999; length = 16'd3; end
            if (done) begin done_cyc = c; break; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        checks++; if (perf_cycles !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d want 0", perf_cycles); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_sqrt_basic();
        logic [7:0] exp_d [3] = '{8'h20, 8'h2D, 8'h00};
        mem[16'h0100] = 8'h20; mem[16'h0101] = 8'h40; mem[16'h0102] = 8'h80;
        run_op(16'h0100, 16'h0200, 16'd3, 0);
        checks++; if (done_cyc !== 6) begin errors++; $display("FAIL basic_done_cycle: got %0d want 6", done_cyc); end
        checks++; if (rd_a.size() !== 3) begin errors++; $display("FAIL basic_rd_count: got %0d want 3", rd_a.size()); end
        checks++; if (wr_a.size() !== 3) begin errors++; $display("FAIL basic_wr_count: got %0d want 3", wr_a.size()); end
        if (rd_a.size() == 3 && wr_a.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (rd_a[k] !== 16'h0100 + 16'(k) || rd_c[k] !== k + 1) begin
                    errors++; $display("FAIL basic_rd%0d: got addr %h cyc %0d", k, rd_a[k], rd_c[k]); end
                checks++; if (wr_a[k] !== 16'h0200 + 16'(k) || wr_c[k] !== k + 3 || wr_d[k] !== exp_d[k]) begin
                    errors++; $display("FAIL basic_wr%0d: got addr %h data %h cyc %0d want data %h",
                                       k, wr_a[k], wr_d[k], wr_c[k], exp_d[k]); end
            end
        end
        @(negedge clk);
        checks++; if (mem[16'h0201] !== 8'h2D) begin errors++; $display("FAIL basic_mem: got %h want 2d", mem[16'h0201]); end
    endtask

    task automatic test_zero_len();
        run_op(16'h0010, 16'h0020, 16'd0, 0);
        checks++; if (done_cyc !== 1) begin errors++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
        checks++; if (busy_cnt !== 1) begin errors++; $display("FAIL zero_busy_cycles: got %0d want 1", busy_cnt); end
        checks++; if (rd_a.size() + wr_a.size() !== 0) begin
            errors++; $display("FAIL zero_traffic: got rd %0d wr %0d want 0", rd_a.size(), wr_a.size()); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_r [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        logic [15:0] exp_w [4] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
        run_op(16'hFFFE, 16'hFFFF, 16'd4, 0);
        checks++; if (rd_a.size() !== 4 || wr_a.size() !== 4) begin
            errors++; $display("FAIL wrap_counts: got rd %0d wr %0d want 4", rd_a.size(), wr_a.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (rd_a[k] !== exp_r[k] || wr_a[k] !== exp_w[k]) begin
                    errors++; $display("FAIL wrap_addr%0d: got rd %h wr %h want rd %h wr %h",
                                       k, rd_a[k], wr_a[k], exp_r[k], exp_w[k]); end
            end
        end
        checks++; if (done_cyc !== 7) begin errors++; $display("FAIL wrap_done_cycle: got %0d want 7", done_cyc); end
    endtask

    task automatic test_back_to_back();
        int bad;
        for (int k = 0; k < 64; k++) mem[16'h0040 + 16'(k)] = 8'(k);
        run_op(16'h0040, 16'h0040, 16'd64, 10);
        @(negedge clk);
        checks++; if (done_cyc !== 67) begin errors++; $display("FAIL inplace_done_cycle: got %0d want 67", done_cyc); end
        checks++; if (wr_a.size() !== 64) begin errors++; $display("FAIL inplace_wr_count: got %0d want 64", wr_a.size()); end
        bad = 0;
        for (int k = 0; k < wr_c.size(); k++) if (wr_c[k] !== k + 3 || wr_a[k] !== 16'h0040 + 16'(k)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL inplace_wr_stream: got %0d bad beats want 0", bad); end
        checks++; if (mem[16'h0060] !== 8'h20) begin errors++; $display("FAIL inplace_mem60: got %h want 20", mem[16'h0060]); end
        checks++; if (mem[16'h0041] !== 8'h05) begin errors++; $display("FAIL inplace_mem41: got %h want 05", mem[16'h0041]); end
        checks++; if (mem[16'h007F] !== 8'h2C) begin errors++; $display("FAIL inplace_mem7f: got %h want 2c", mem[16'h007F]); end
        bad = 0;
        for (int k = 0; k < 64; k++) if (mem[16'h0040 + 16'(k)] !== sqrt_model(8'(k))) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL inplace_all: got %0d wrong bytes want 0", bad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inplace_restart_ignored: got busy %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int nrd, bad;
        for (int k = 0; k < 10; k++) mem[16'h0300 + 16'(k)] = 8'(k + 1);
        nrd = 0;
        @(negedge clk);
        src_base = 16'h0300; dst_base = 16'h0400; length = 16'd10; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (rd_en) nrd++;
        end
        checks++; if (nrd !== 5) begin errors++; $display("FAIL rstmid_reads: got %0d want 5", nrd); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, rd_en, wr_en} !== 4'b0000 || rd_addr !== 16'h0 || wr_addr !== 16'h0) begin
            errors++; $display("FAIL rstmid_outputs: got busy %b done %b rd %b wr %b ra %h wa %h want all 0",
                               busy, done, rd_en, wr_en, rd_addr, wr_addr); end
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (wr_en || done || busy) bad++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (wr_en || done || busy) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); end
        mem[16'h0500] = 8'h08; mem[16'h0501] = 8'h7F;
        run_op(16'h0500, 16'h0600, 16'd2, 0);
        checks++; if (done_cyc !== 5) begin errors++; $display("FAIL rstmid_rerun_done: got %0d want 5", done_cyc); end
        checks++; if (wr_d.size() !== 2 || wr_d[0] !== 8'h10 || wr_d[1] !== 8'h3F) begin
            errors++; $display("FAIL rstmid_rerun_data: got %0d writes want 2 (10,3f)", wr_d.size()); end
    endtask

    task automatic test_perf();
        logic [31:0] exp_p;
`ifdef GRAPH_UNARY_PERF_EN
        exp_p = 32'd13;
`else
        exp_p = 32'd0;
`endif
        run_op(16'h0800, 16'h0900, 16'd10, 0);
        @(negedge clk);
        checks++; if (perf_cycles !== exp_p) begin errors++; $display("FAIL perf_after_done: got %0d want %0d", perf_cycles, exp_p); end
        repeat (4) @(negedge clk);
        checks++; if (perf_cycles !== exp_p) begin errors++; $display("FAIL perf_hold_idle: got %0d want %0d", perf_cycles, exp_p); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_sqrt_basic();
        test_zero_len();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/graph_unary_lut_stream.md
Name: graph_unary_lut_stream

Overview:
- Streaming sequencer that feeds the graph engine's 256-entry unary-op ROM (SQRT/EXP/etc. LUTs with 1-cycle registered output) and consumes its result.
- Reads a contiguous int8 tensor from scratchpad SRAM, drives each byte as the LUT address, and writes the LUT output to a destination buffer.
- Sustains 1 element/cycle; sits between the graph dispatcher (start/done) and scratchpad SRAM.

Parameters:
ADDR_W, 16, scratchpad byte-address width
LEN_W, 16, element-count width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe, sampled only when idle
src_base  in  ADDR_W  first source address
dst_base  in  ADDR_W  first destination address
length  in  LEN_W  element count (0 allowed)
busy  out  1  high from the cycle after accepted start through the done cycle
done  out  1  1-cycle completion pulse
rd_en  out  1  SRAM read strobe
rd_addr  out  ADDR_W  SRAM read address
rd_data  in  8  SRAM read data, valid 1 cycle after rd_en
lut_addr  out  8  LUT index (combinational = rd_data)
lut_data  in  8  LUT result, valid 1 cycle after lut_addr
wr_en  out  1  SRAM write strobe
wr_addr  out  ADDR_W  SRAM write address
wr_data  out  8  write data (combinational = lut_data)
perf_cycles  out  32  busy-cycle counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - All registered outputs and internal state are 0.
  - FSM is IDLE.
  - busy, done, rd_en and wr_en are 0.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 latches src_base, dst_base and length, and clears the element counter i.
  - Goes to READ if length!=0.
  - Goes to DONE if length==0. No rd_en or wr_en is ever asserted in that case.
- READ:
  - Each cycle: rd_en=1, rd_addr=src+i, then i increments.
  - After issuing i=length-1, goes to DRAIN.
  - Reads are issued on consecutive cycles with no gaps.
- Data pipeline:
  - Stage 1 is rd_valid/addr; stage 2 is lut_valid/addr. Both are registered.
  - A read issued at cycle k gives rd_data at k+1, which drives lut_addr the same cycle.
  - lut_data arrives at k+2.
  - At k+2: wr_en=1, wr_addr=dst+i_k, wr_data=lut_data.
  - wr_en and wr_addr come from the stage-2 pipeline registers.
  - lut_addr is driven only from rd_data; it holds no meaning when stage 1 is invalid, and writes are gated by valid.
- DRAIN: lasts 2 cycles while the pipeline empties (last write occurs in the 2nd DRAIN cycle), then goes to DONE.
- DONE: done=1 for 1 cycle, then IDLE.
- busy: 1 in READ, DRAIN and DONE.
- Timing for length N≥1, start sampled at cycle 0:
  - Reads in cycles 1..N.
  - Writes in cycles 3..N+2.
  - done in cycle N+3.
- Timing for length 0: done in cycle 1.
- Address arithmetic is modulo 2^ADDR_W; wrap past the top address is silent and legal.
- start while busy is ignored. Latched parameters do not change mid-operation.
- Source and destination may be identical (in-place). This is safe because each write lands 2 cycles after its own read, at the same offset, and later reads are at higher offsets.
- Reset mid-operation:
  - Operation is abandoned immediately.
  - Pipeline valids are cleared, so no further wr_en.
  - No done pulse.

Optional Feature:
- Macro GRAPH_UNARY_PERF_EN.
- When defined: perf_cycles is a 32-bit counter.
  - Clears on accepted start.
  - Increments every cycle busy=1.
  - Holds its value in IDLE.
  - Saturates at 0xFFFFFFFF.
  - Reset value 0.
  - Expected value after a run = N+3 (1 for N=0).
- When undefined: perf_cycles is tied to 0 and no counter logic exists.

Test Plan:
- SQRT LUT model; src_base=0x0100, dst_base=0x0200, length=3, source {0x20, 0x40, 0x80} → writes {0x20, 0x2D, 0x00} at 0x0200..0x0202 in cycles 3..5, done at cycle 6.
- length=0 → busy high and done pulse in cycle 1 only; zero rd_en and zero wr_en.
- src_base=0xFFFE, dst_base=0xFFFF, length=4 → reads 0xFFFE, 0xFFFF, 0x0000, 0x0001; writes 0xFFFF, 0x0000, 0x0001, 0x0002.
- In-place: src=dst=0x0040, length=64, ramp 0..63 → each byte i replaced by sqrt_lut(i), e.g. addr 0x0060 (i=32) becomes 0x20; back-to-back writes with no bubbles; a second start during the run is ignored.
- rst_n asserted asynchronously mid-READ (after 5 of 10 reads) → all outputs 0 immediately, no done. A new start with length=2 then completes normally, done at cycle 5.
- With GRAPH_UNARY_PERF_EN, length=10 → perf_cycles=13 after done. Without the macro → perf_cycles stays 0.
